ccsds_turbo_dec_obuf_ctrl: RTL and testbench

CCSDS_TURBO_DEC_OBUF_CTRL -- requirements
Module: ccsds_turbo_dec_obuf_ctrl

---
 rtl/ccsds_turbo_dec_obuf_ctrl.sv | 100 ++++++++++
 tb/tb_ccsds_turbo_dec_obuf_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds_turbo_dec_obuf_ctrl.sv
// Turbo decoder output buffer controller.
// Two-bank ping-pong FIFO between decoder and frame sink.
module ccsds_turbo_dec_obuf_ctrl #(
    parameter int pTAG_W = 8,
    parameter int pERR_W = 16
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              iwfull,
    input  logic [pTAG_W-1:0] iwtag,
    input  logic [pERR_W-1:0] iwerr,
    output logic              owready,
    output logic              owbank,
    output logic              orfull,
    output logic              orbank,
    output logic [pTAG_W-1:0] ortag,
    output logic [pERR_W-1:0] orerr,
    input  logic              irempty,
    output logic [1:0]        oused,
    output logic              oovf,
    output logic [15:0]       ofrm_cnt
);

    logic              wp;
    logic              rp;
    logic [1:0]        cnt;
    logic              ovf;
    logic [15:0]       frm_cnt;
    logic [pTAG_W-1:0] tag [2];
    logic [pERR_W-1:0] err [2];

    logic              rel_ok;
    logic              com_ok;
    logic              ovf_set;
    logic [1:0]        cnt_nxt;

    // Accept/drop decisions; a release in the same cycle frees a full buffer.
    always_comb begin
        rel_ok  = iclkena & irempty & (cnt != 2'd0);
        com_ok  = iclkena & iwfull & ((cnt != 2'd2) | rel_ok);
        ovf_set = iclkena & iwfull & ~com_ok;
        cnt_nxt = cnt;
        unique case ({com_ok, rel_ok})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointers, occupancy, overflow flag and released-frame counter.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wp      <= 1'b0;
            rp      <= 1'b0;
            cnt     <= 2'd0;
            ovf     <= 1'b0;
            frm_cnt <= 16'd0;
        end else begin
            if (com_ok) begin
                wp <= ~wp;
            end
            if (rel_ok) begin
                rp      <= ~rp;
                frm_cnt <= frm_cnt + 16'd1;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
            cnt <= cnt_nxt;
        end
    end

    // Per-bank frame descriptors, loaded into the bank being committed.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            tag[0] <= '0;
            tag[1] <= '0;
            err[0] <= '0;
            err[1] <= '0;
        end else if (com_ok) begin
            tag[wp] <= iwtag;
            err[wp] <= iwerr;
        end
    end

    // Outputs decoded directly from registered state.
    always_comb begin
        owready  = (cnt != 2'd2);
        owbank   = wp;
        orfull   = (cnt != 2'd0);
        orbank   = rp;
        ortag    = tag[rp];
        orerr    = err[rp];
        oused    = cnt;
        oovf     = ovf;
        ofrm_cnt = frm_cnt;
    end

endmodule

// File: tb/tb_ccsds_turbo_dec_obuf_ctrl.sv
// Directed bench for the output buffer controller.
// Expected values are hand-derived per step.
module tb_ccsds_turbo_dec_obuf_ctrl;

    logic        iclk;
    logic        ireset;
    logic        iclkena;
    logic        iwfull;
    logic [7:0]  iwtag;
    logic [15:0] iwerr;
    logic        owready;
    logic        owbank;
    logic        orfull;
    logic        orbank;
    logic [7:0]  ortag;
    logic [15:0] orerr;
    logic        irempty;
    logic [1:0]  oused;
    logic        oovf;
    logic [15:0] ofrm_cnt;

    int checks;
    int errors;

    ccsds_turbo_dec_obuf_ctrl #(
        .pTAG_W(8),
        .pERR_W(16)
    ) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iwfull  (iwfull),
        .iwtag   (iwtag),
        .iwerr   (iwerr),
        .owready (owready),
        .owbank  (owbank),
        .orfull  (orfull),
        .orbank  (orbank),
        .ortag   (ortag),
        .orerr   (orerr),
        .irempty (irempty),
        .oused   (oused),
        .oovf    (oovf),
        .ofrm_cnt(ofrm_cnt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic cyc(input logic wf, input logic [7:0] tg,
                       input logic [15:0] er, input logic re,
                       input logic en);
        iwfull  = wf;
        iwtag   = tg;
        iwerr   = er;
        irempty = re;
        iclkena = en;
        @(posedge iclk);
        #1;
        iwfull  = 1'b0;
        irempty = 1'b0;
        iclkena = 1'b1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_owready"}, 32'(owready), 32'd1);
        chk({pfx, "_owbank"}, 32'(owbank), 32'd0);
        chk({pfx, "_orfull"}, 32'(orfull), 32'd0);
        chk({pfx, "_orbank"}, 32'(orbank), 32'd0);
        chk({pfx, "_ortag"}, 32'(ortag), 32'd0);
        chk({pfx, "_orerr"}, 32'(orerr), 32'd0);
        chk({pfx, "_oused"}, 32'(oused), 32'd0);
        chk({pfx, "_oovf"}, 32'(oovf), 32'd0);
        chk({pfx, "_frm"}, 32'(ofrm_cnt), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge iclk);
        ireset = 1'b1;
        #2;
        ireset = 1'b0;
        @(posedge iclk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ireset  = 1'b1;
        iclkena = 1'b1;
        iwfull  = 1'b0;
        irempty = 1'b0;
        iwtag   = '0;
        iwerr   = '0;
        #12;
        chk_reset_vals("rst");
        ireset = 1'b0;
        @(posedge iclk);
        #1;

        // single frame
        cyc(1'b1, 8'h11, 16'd5, 1'b0, 1'b1);
        chk("s_orfull", 32'(orfull), 32'd1);
        chk("s_orbank", 32'(orbank), 32'd0);
        chk("s_ortag", 32'(ortag), 32'h11);
        chk("s_orerr", 32'(orerr), 32'd5);
        chk("s_owbank", 32'(owbank), 32'd1);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("s_orfull2", 32'(orfull), 32'd0);
        chk("s_frm", 32'(ofrm_cnt), 32'd1);
        chk("s_oused", 32'(oused), 32'd0);
        chk("s_orbank2", 32'(orbank), 32'd1);

        // fill and overflow (wp = rp = 1 here)
        cyc(1'b1, 8'hA1, 16'd1, 1'b0, 1'b1);
        cyc(1'b1, 8'hA2, 16'd2, 1'b0, 1'b1);
        chk("f_oused", 32'(oused), 32'd2);
        chk("f_owready", 32'(owready), 32'd0);
        chk("f_ortag", 32'(ortag), 32'hA1);
        chk("f_oovf0", 32'(oovf), 32'd0);
        cyc(1'b1, 8'hA3, 16'd3, 1'b0, 1'b1);
        chk("f_oovf", 32'(oovf), 32'd1);
        chk("f_oused2", 32'(oused), 32'd2);
        chk("f_ortag2", 32'(ortag), 32'hA1);
        chk("f_orerr2", 32'(orerr), 32'd1);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("f_rel1_tag", 32'(ortag), 32'hA2);
        chk("f_rel1_err", 32'(orerr), 32'd2);
        chk("f_rel1_bank", 32'(orbank), 32'd0);
        chk("f_rel1_used", 32'(oused), 32'd1);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("f_rel2_used", 32'(oused), 32'd0);
        chk("f_rel2_full", 32'(orfull), 32'd0);
        chk("f_rel2_frm", 32'(ofrm_cnt), 32'd3);

        // spurious release
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("sp_orbank", 32'(orbank), 32'd1);
        chk("sp_frm", 32'(ofrm_cnt), 32'd3);
        chk("sp_oovf", 32'(oovf), 32'd1);
        chk("sp_oused", 32'(oused), 32'd0);

        // clock enable gating, then async reset with a frame held
        do_reset();
        chk_reset_vals("r2");
        cyc(1'b1, 8'hB5, 16'd9, 1'b0, 1'b0);
        chk("ce_oused", 32'(oused), 32'd0);
        cyc(1'b0, 8'h00, 16'd0, 1'b0, 1'b1);
        chk("ce_oused2", 32'(oused), 32'd0);
        cyc(1'b1, 8'h44, 16'd7, 1'b0, 1'b1);
        chk("ce_hold", 32'(oused), 32'd1);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b0);
        chk("ce_rel_ign", 32'(oused), 32'd1);
        #2;
        ireset = 1'b1;
        #1;
        chk_reset_vals("ar");
        @(negedge iclk);
        ireset = 1'b0;
        @(posedge iclk);
        #1;
        chk("ar_after", 32'(oused), 32'd0);

        // simultaneous commit and release with a full buffer
        cyc(1'b1, 8'hC1, 16'd1, 1'b0, 1'b1);
        cyc(1'b1, 8'hC2, 16'd2, 1'b0, 1'b1);
        chk("sim_pre", 32'(oused), 32'd2);
        cyc(1'b1, 8'h33, 16'h33, 1'b1, 1'b1);
        chk("sim_oused", 32'(oused), 32'd2);
        chk("sim_oovf", 32'(oovf), 32'd0);
        chk("sim_orbank", 32'(orbank), 32'd1);
        chk("sim_ortag", 32'(ortag), 32'hC2);
        chk("sim_owbank", 32'(owbank), 32'd1);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("sim_r1_tag", 32'(ortag), 32'h33);
        chk("sim_r1_err", 32'(orerr), 32'h33);
        chk("sim_r1_bank", 32'(orbank), 32'd0);
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("sim_r2_used", 32'(oused), 32'd0);
        chk("sim_r2_frm", 32'(ofrm_cnt), 32'd3);

        // simultaneous commit and release with an empty buffer
        cyc(1'b1, 8'hD1, 16'd4, 1'b1, 1'b1);
        chk("e_oused", 32'(oused), 32'd1);
        chk("e_frm", 32'(ofrm_cnt), 32'd3);
        chk("e_ortag", 32'(ortag), 32'hD1);
        chk("e_orbank", 32'(orbank), 32'd1);

        // counter wrap over 65536 released frames
        do_reset();
        cyc(1'b1, 8'h00, 16'd0, 1'b0, 1'b1);
        for (int i = 1; i < 65536; i++) begin
            cyc(1'b1, 8'(i), 16'(i), 1'b1, 1'b1);
            chk("w_orbank", 32'(orbank), 32'(i & 1));
            if ((i & 16'h0FFF) == 0) begin
                chk("w_ortag", 32'(ortag), 32'(i & 8'hFF));
                chk("w_oused", 32'(oused), 32'd1);
                chk("w_frm", 32'(ofrm_cnt), 32'(i));
            end
        end
        cyc(1'b0, 8'h00, 16'd0, 1'b1, 1'b1);
        chk("w_frm_wrap", 32'(ofrm_cnt), 32'd0);
        chk("w_oused_end", 32'(oused), 32'd0);
        chk("w_orbank_end", 32'(orbank), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
